// File: rtl/alu_ctrl_pkg.sv
// Shared EX-stage ALU/MDU encodings: ALU select codes, R-type function codes,
// ALUOp codes and the MDU state/operation types.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_MFHI = 4'b1100;
    localparam logic [3:0] ALU_MFLO = 4'b1101;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_IMM = 2'b11;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;

    // Ordering matches funct[1:0] of mult/multu/div/divu.
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide core: one shift-add or restoring shift-subtract step per cycle,
// sign fixup in FIX. MDU_EARLY_TERM_EN enables early termination of multiplies.
module md_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_t           op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             busy,
    output logic             fix,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   areg;
    logic [2*WIDTH-1:0] p;
    logic               is_div, neg_q, neg_r, dz;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, r_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: p = {accumulator, multiplier}; divide: p = {remainder, quotient/dividend}.
    assign sum      = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? areg : '0)};
    assign mul_next = {sum, p[WIDTH-1:1]};
    assign r_sh     = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign diff     = r_sh - {1'b0, areg};
    assign div_next = diff[WIDTH] ? {r_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

`ifdef MDU_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             early;
    // Low cnt-1 bits of the lower half are the multiplier bits not yet consumed.
    assign rem_mask = (WIDTH'(1) << (cnt - CNT_W'(1))) - WIDTH'(1);
    assign early    = ~is_div & ((mul_next[WIDTH-1:0] & rem_mask) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            areg   <= '0;
            p      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state  <= MD_RUN;
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (b == '0);
                        areg   <= op[1] ? b_mag : a_mag;
                        p      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    end
                end
                MD_RUN: begin
                    if (abort) begin
                        state <= MD_IDLE;
                        cnt   <= '0;
                    end else begin
                        p   <= is_div ? div_next : mul_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= MD_FIX;
`ifdef MDU_EARLY_TERM_EN
                        if (early) begin
                            p     <= mul_next >> (cnt - CNT_W'(1));
                            cnt   <= '0;
                            state <= MD_FIX;
                        end
`endif
                    end
                end
                MD_FIX:  state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        prod   = neg_q ? -p : p;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
            res_lo = dz ? '1 : (neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
        end
    end

    assign idle = (state == MD_IDLE);
    assign busy = (state == MD_RUN);
    assign fix  = (state == MD_FIX);
    assign done = fix & ~abort;

endmodule

// File: rtl/mdu_alu_control.sv
// EX-stage ALU control with iterative MDU and HI/LO registers.
// Optional macro MDU_EARLY_TERM_EN: early-terminating multiplies in md_iter_core.
module mdu_alu_control
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       alu_ctrl,
    output logic             md_busy,
    output logic             md_done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             r_type, is_md, is_mt, md_idle, md_fix, start, mt_accept;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_IMM: alu_ctrl = ALU_ADD;
            ALUOP_R: begin
                case (funct)
                    F_SLL:   alu_ctrl = ALU_SLL;
                    F_SRL:   alu_ctrl = ALU_SRL;
                    F_SRA:   alu_ctrl = ALU_SRA;
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_XOR:   alu_ctrl = ALU_XOR;
                    F_NOR:   alu_ctrl = ALU_NOR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    F_MFHI:  alu_ctrl = ALU_MFHI;
                    F_MFLO:  alu_ctrl = ALU_MFLO;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default:   alu_ctrl = ALU_ADD;
        endcase
    end

    assign r_type    = (alu_op == ALUOP_R);
    assign is_md     = r_type & (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign is_mt     = r_type & ((funct == F_MTHI) | (funct == F_MTLO));
    assign start     = valid_in & ~flush & is_md & md_idle;
    assign mt_accept = valid_in & ~flush & is_mt & md_idle;

    // Only MDU-touching instructions wait; everything else flows past a running op.
    assign stall = valid_in & (md_busy | md_fix) & r_type & is_mdu_funct(funct);

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (md_op_t'(funct[1:0])),
        .abort  (flush),
        .a      (rs_data),
        .b      (rt_data),
        .idle   (md_idle),
        .busy   (md_busy),
        .fix    (md_fix),
        .done   (md_done),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (mt_accept) begin
            if (funct == F_MTHI) hi <= rs_data;
            else                 lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_mdu_alu_control.sv
// Self-checking bench for mdu_alu_control: arithmetic reference model compared every
// cycle, plus directed vectors with literal expectations. Honors MDU_EARLY_TERM_EN.
module tb_mdu_alu_control;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic          valid_in, flush;
    logic [W-1:0]  rs_data, rt_data;
    logic [3:0]    alu_ctrl;
    logic          md_busy, md_done, stall;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    mdu_alu_control #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct),
        .valid_in(valid_in), .flush(flush), .rs_data(rs_data), .rt_data(rt_data),
        .alu_ctrl(alu_ctrl), .md_busy(md_busy), .md_done(md_done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
        if (op != 2'b10) return (op == 2'b01) ? 4'h6 : 4'h2;
        case (f)
            0: return 4'h3;   2: return 4'h4;   3: return 4'h5;
            32: return 4'h2;  34: return 4'h6;  36: return 4'h0;
            37: return 4'h1;  38: return 4'hA;  39: return 4'hB;
            42: return 4'h7;  16: return 4'hC;  18: return 4'hD;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] md_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'd24: return 64'(sa * sb);
            6'd25: return {32'b0, a} * {32'b0, b};
            6'd26: if (b == 0) return {a, 32'hFFFF_FFFF};
                   else        return {32'(sa % sb), 32'(sa / sb)};
            6'd27: if (b == 0) return {a, 32'hFFFF_FFFF};
                   else        return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Edges from the start edge until HI/LO are written.
    function automatic int md_lat(input logic [5:0] f, input logic [W-1:0] b);
`ifdef MDU_EARLY_TERM_EN
        if (f == 6'd24 || f == 6'd25) begin
            logic [W-1:0] m;
            int steps;
            m = (f == 6'd24 && b[W-1]) ? -b : b;
            steps = 1;
            for (int i = 0; i < W; i++) if (m[i]) steps = i + 1;
            return steps + 1;
        end
`endif
        return W + 1;
    endfunction

    int           m_rem;
    logic [W-1:0] m_hi, m_lo, m_phi, m_plo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0; m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0;
        end else if (m_rem > 0) begin
            if (flush) m_rem <= 0;
            else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin m_hi <= m_phi; m_lo <= m_plo; end
            end
        end else if (valid_in && !flush && alu_op == 2'b10) begin
            if (funct inside {[24:27]}) begin
                {m_phi, m_plo} <= md_ref(funct, rs_data, rt_data);
                m_rem <= md_lat(funct, rt_data);
            end else if (funct == 6'd17) m_hi <= rs_data;
            else if (funct == 6'd19)     m_lo <= rs_data;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("alu_ctrl", 64'(alu_ctrl), 64'(ref_alu(alu_op, funct)));
            check("md_busy",  64'(md_busy),  64'(m_rem > 1));
            check("md_done",  64'(md_done),  64'(m_rem == 1 && !flush));
            check("stall",    64'(stall),
                  64'(valid_in && m_rem > 0 && alu_op == 2'b10 && (funct inside {[16:19], [24:27]})));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the edge that accepted the instruction.
    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int cyc);
        logic st;
        alu_op = op; funct = f; rs_data = a; rt_data = b; valid_in = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); st = stall;
            @(posedge clk); #1;
            cyc++;
        end while (st && cyc < 100);
        if (st) check("issue_accept", 64'(st), 64'd0);
        valid_in = 1'b0;
    endtask

    // Counts falling edges until md_done is seen; leaves time just after the write edge.
    task automatic wait_done(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!md_done && n < 60);
        if (!md_done) check("done_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct { logic [1:0] op; logic [5:0] f; logic [3:0] e; } dvec_t;
    dvec_t dv [22] = '{
        '{2'd0, 6'd0, 4'h2}, '{2'd1, 6'd0, 4'h6}, '{2'd3, 6'd0, 4'h2},
        '{2'd2, 6'd0, 4'h3}, '{2'd2, 6'd2, 4'h4}, '{2'd2, 6'd3, 4'h5},
        '{2'd2, 6'd32, 4'h2}, '{2'd2, 6'd34, 4'h6}, '{2'd2, 6'd36, 4'h0},
        '{2'd2, 6'd37, 4'h1}, '{2'd2, 6'd38, 4'hA}, '{2'd2, 6'd39, 4'hB},
        '{2'd2, 6'd42, 4'h7}, '{2'd2, 6'd16, 4'hC}, '{2'd2, 6'd18, 4'hD},
        '{2'd2, 6'd24, 4'h2}, '{2'd2, 6'd25, 4'h2}, '{2'd2, 6'd26, 4'h2},
        '{2'd2, 6'd27, 4'h2}, '{2'd2, 6'd17, 4'h2}, '{2'd2, 6'd19, 4'h2},
        '{2'd2, 6'd63, 4'h2}
    };

`ifdef MDU_EARLY_TERM_EN
    localparam int LAT_M37 = 4;
    localparam int LAT_51  = 2;
`else
    localparam int LAT_M37 = 33;
    localparam int LAT_51  = 33;
`endif

    initial begin
        int c, n;
        rst_n = 1'b0; alu_op = 2'b00; funct = 6'd0; valid_in = 1'b0; flush = 1'b0;
        rs_data = '0; rt_data = '0;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(md_busy), 64'd0);
        check("rst_done", 64'(md_done), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;

        // Decode sweep
        foreach (dv[i]) begin
            alu_op = dv[i].op; funct = dv[i].f;
            #3 check($sformatf("decode_%0d_%0d", dv[i].op, dv[i].f), 64'(alu_ctrl), 64'(dv[i].e));
            @(posedge clk); #1;
        end

        // mthi / mtlo
        issue(2'd2, 6'd17, 32'h1234_5678, 32'd0, c);
        check("mthi", 64'(hi), 64'h1234_5678);
        issue(2'd2, 6'd19, 32'h9ABC_DEF0, 32'd0, c);
        check("mtlo", 64'(lo), 64'h9ABC_DEF0);

        // mult -3*7
        issue(2'd2, 6'd24, 32'hFFFF_FFFD, 32'd7, c);
        wait_done(n);
        check("mult_latency", 64'(n), 64'(LAT_M37));
        check("mult_done_pulse", 64'(md_done), 64'd0);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

        // multu FFFFFFFF*2
        issue(2'd2, 6'd25, 32'hFFFF_FFFF, 32'd2, c);
        wait_done(n);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        // div -7/2
        issue(2'd2, 6'd26, 32'hFFFF_FFF9, 32'd2, c);
        wait_done(n);
        check("div_latency", 64'(n), 64'd33);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);

        // divu 100/0
        issue(2'd2, 6'd27, 32'd100, 32'd0, c);
        wait_done(n);
        check("divz_hi", 64'(hi), 64'd100);
        check("divz_lo", 64'(lo), 64'hFFFF_FFFF);

        // mflo behind a running mult stalls and then sees the new lo
        issue(2'd2, 6'd24, 32'd6, 32'd7, c);
        issue(2'd2, 6'd18, 32'd0, 32'd0, c);
        check("mflo_stalled", 64'(c > 1), 64'd1);
        check("mflo_lo", 64'(lo), 64'd42);

        // add issued behind a running mult never stalls
        issue(2'd2, 6'd24, 32'h0001_0000, 32'h0001_0000, c);
        issue(2'd2, 6'd32, 32'd1, 32'd2, c);
        check("add_no_stall", 64'(c), 64'd1);
        wait_done(n);
        check("big_hi", 64'(hi), 64'h1);
        check("big_lo", 64'(lo), 64'h0);

        // flush in the start cycle suppresses the start
        alu_op = 2'd2; funct = 6'd24; rs_data = 32'd3; rt_data = 32'd3;
        valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(md_busy), 64'd0);

        // flush at RUN cycle 10 aborts with hi/lo unchanged
        issue(2'd2, 6'd24, 32'h7FFF_FFFF, 32'h4000_0001, c);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_busy", 64'(md_busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hi", 64'(hi), 64'h1);
        check("flush_lo", 64'(lo), 64'h0);

        // async reset mid-operation
        issue(2'd2, 6'd27, 32'd1000, 32'd7, c);
        repeat (4) @(posedge clk);
        alu_op = 2'd2; funct = 6'd18; valid_in = 1'b1;
        #1 check("pre_rst_stall", 64'(stall), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(md_busy), 64'd0);
        check("arst_done", 64'(md_done), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;

        // multu 5*1 latency (early termination when enabled)
        issue(2'd2, 6'd25, 32'd5, 32'd1, c);
        wait_done(n);
        check("multu51_latency", 64'(n), 64'(LAT_51));
        check("multu51_hi", 64'(hi), 64'd0);
        check("multu51_lo", 64'(lo), 64'd5);

        repeat (3) @(posedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
